// File: rtl/spi_tone_command_decoder_pkg.sv
// Shared command encoding, field widths and decoder state type for the tone command path.
package music_box_pkg;
  localparam int FREQ_W     = 14;
  localparam int AMP_W      = 8;
  localparam int SPI_WORD_W = 16;

  typedef enum logic [1:0] {CMD_NOP, CMD_FREQ, CMD_AMP, CMD_COMMIT} spi_cmd_t;

  typedef enum logic {ST_IDLE, ST_COLLECT} decoder_state_t;
endpackage

// File: rtl/spi_tone_command_decoder_frame_timeout_counter.sv
// Saturating frame timer: clear wins, counts while enabled, flags the last allowed cycle.
module frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 50_000
) (
  input  logic CLK_50Mhz,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal_count
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Holds at LAST instead of wrapping so a suppressed timeout fires on the next quiet cycle.
  always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign terminal_count = enable && (count == LAST);
endmodule

// File: rtl/spi_tone_command_decoder.sv
// Collects FREQ/AMP command words into shadows and applies them atomically on COMMIT.
module spi_tone_command_decoder
  import music_box_pkg::*;
#(
  parameter int                 TIMEOUT_CYCLES = 50_000,
  parameter logic [FREQ_W-1:0]  FREQ_MAX       = 14'd12000,
  parameter logic [AMP_W-1:0]   AMP_MAX        = 8'd255
) (
  input  logic                  CLK_50Mhz,
  input  logic                  reset_n,
  input  logic                  in_wordValid,
  input  logic [SPI_WORD_W-1:0] in_word,
  output logic [FREQ_W-1:0]     out_frequency,
  output logic [AMP_W-1:0]      out_amplitude,
  output logic                  out_update,
  output logic                  out_frameError,
  output logic                  out_clamped,
  output logic                  out_busy
);
  function automatic logic [FREQ_W-1:0] clamp_freq(input logic [FREQ_W-1:0] v);
    return (v > FREQ_MAX) ? FREQ_MAX : v;
  endfunction

  function automatic logic [AMP_W-1:0] clamp_amp(input logic [AMP_W-1:0] v);
    return (v > AMP_MAX) ? AMP_MAX : v;
  endfunction

  // Stage p0: register the incoming word
  logic                  vld_p0;
  logic [SPI_WORD_W-1:0] word_p0;

  always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
    if (!reset_n) vld_p0 <= 1'b0;
    else          vld_p0 <= in_wordValid;
  end

  always_ff @(posedge CLK_50Mhz) word_p0 <= in_word;

  spi_cmd_t cmd_p0;
  logic     is_data_p0, is_commit_p0;

  assign cmd_p0       = spi_cmd_t'(word_p0[15:14]);
  assign is_data_p0   = vld_p0 && ((cmd_p0 == CMD_FREQ) || (cmd_p0 == CMD_AMP));
  assign is_commit_p0 = vld_p0 && (cmd_p0 == CMD_COMMIT);

  // Stage p1: frame FSM, shadows and committed outputs
  decoder_state_t    state, state_nxt;
  logic [FREQ_W-1:0] shadow_freq, shadow_freq_nxt, freq_nxt;
  logic [AMP_W-1:0]  shadow_amp, shadow_amp_nxt, amp_nxt;
  logic              freq_pending, freq_pending_nxt, amp_pending, amp_pending_nxt;
  logic              clamped_nxt, update_nxt, error_nxt;
  logic              timer_clear, timer_enable, timer_tc;

  assign timer_enable = (state == ST_COLLECT);

  frame_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .CLK_50Mhz      (CLK_50Mhz),
    .reset_n        (reset_n),
    .clear          (timer_clear),
    .enable         (timer_enable),
    .terminal_count (timer_tc)
  );

  always_comb begin
    state_nxt        = state;
    shadow_freq_nxt  = shadow_freq;
    shadow_amp_nxt   = shadow_amp;
    freq_pending_nxt = freq_pending;
    amp_pending_nxt  = amp_pending;
    freq_nxt         = out_frequency;
    amp_nxt          = out_amplitude;
    clamped_nxt      = out_clamped;
    update_nxt       = 1'b0;
    error_nxt        = 1'b0;
    timer_clear      = 1'b0;

    if (vld_p0 && (cmd_p0 == CMD_FREQ)) begin
      shadow_freq_nxt  = word_p0[FREQ_W-1:0];
      freq_pending_nxt = 1'b1;
    end
    if (vld_p0 && (cmd_p0 == CMD_AMP)) begin
      shadow_amp_nxt  = word_p0[AMP_W-1:0];
      amp_pending_nxt = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        timer_clear = 1'b1;
        if (is_data_p0)        state_nxt = ST_COLLECT;
        else if (is_commit_p0) error_nxt = 1'b1;
      end
      ST_COLLECT: begin
        if (is_data_p0) begin
          timer_clear = 1'b1;
        end else if (is_commit_p0) begin
          state_nxt   = ST_IDLE;
          timer_clear = 1'b1;
          update_nxt  = 1'b1;
          if (freq_pending) begin
            freq_nxt = clamp_freq(shadow_freq);
            if (shadow_freq > FREQ_MAX) clamped_nxt = 1'b1;
          end
          if (amp_pending) begin
            amp_nxt = clamp_amp(shadow_amp);
            if (shadow_amp > AMP_MAX) clamped_nxt = 1'b1;
          end
          freq_pending_nxt = 1'b0;
          amp_pending_nxt  = 1'b0;
        end else if (timer_tc && !vld_p0) begin
          state_nxt        = ST_IDLE;
          timer_clear      = 1'b1;
          error_nxt        = 1'b1;
          shadow_freq_nxt  = '0;
          shadow_amp_nxt   = '0;
          freq_pending_nxt = 1'b0;
          amp_pending_nxt  = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      shadow_freq    <= '0;
      shadow_amp     <= '0;
      freq_pending   <= 1'b0;
      amp_pending    <= 1'b0;
      out_frequency  <= '0;
      out_amplitude  <= '0;
      out_update     <= 1'b0;
      out_frameError <= 1'b0;
      out_clamped    <= 1'b0;
    end else begin
      state          <= state_nxt;
      shadow_freq    <= shadow_freq_nxt;
      shadow_amp     <= shadow_amp_nxt;
      freq_pending   <= freq_pending_nxt;
      amp_pending    <= amp_pending_nxt;
      out_frequency  <= freq_nxt;
      out_amplitude  <= amp_nxt;
      out_update     <= update_nxt;
      out_frameError <= error_nxt;
      out_clamped    <= clamped_nxt;
    end
  end

  assign out_busy = (state == ST_COLLECT);
endmodule

// File: tb/tb_spi_tone_command_decoder.sv
// Directed bench for spi_tone_command_decoder with a short frame timeout.
module tb_spi_tone_command_decoder;
  localparam int TB_TIMEOUT = 16;

  logic        CLK_50Mhz = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_wordValid = 1'b0;
  logic [15:0] in_word = 16'h0000;
  logic [13:0] out_frequency;
  logic [7:0]  out_amplitude;
  logic        out_update, out_frameError, out_clamped, out_busy;

  int n_vec = 0;
  int n_err = 0;

  spi_tone_command_decoder #(
    .TIMEOUT_CYCLES (TB_TIMEOUT),
    .FREQ_MAX       (14'd12000),
    .AMP_MAX        (8'd255)
  ) dut (
    .CLK_50Mhz      (CLK_50Mhz),
    .reset_n        (reset_n),
    .in_wordValid   (in_wordValid),
    .in_word        (in_word),
    .out_frequency  (out_frequency),
    .out_amplitude  (out_amplitude),
    .out_update     (out_update),
    .out_frameError (out_frameError),
    .out_clamped    (out_clamped),
    .out_busy       (out_busy)
  );

  always #5 CLK_50Mhz = ~CLK_50Mhz;

  // Drive one cycle of input, then land on the following falling edge.
  task automatic step(input logic v, input logic [15:0] w);
    in_wordValid = v;
    in_word      = w;
    @(negedge CLK_50Mhz);
    in_wordValid = 1'b0;
    in_word      = 16'h0000;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge CLK_50Mhz);
    n_vec++;
    if ({out_frequency, out_amplitude, out_update, out_frameError, out_clamped, out_busy} !== 26'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0",
               {out_frequency, out_amplitude, out_update, out_frameError, out_clamped, out_busy});
    end
    reset_n = 1'b1;
    @(negedge CLK_50Mhz);
  endtask

  task automatic test_basic_commit;
    step(1'b1, 16'h41B8);
    step(1'b1, 16'h8080);
    n_vec++;
    if (out_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_high: got %b expected 1", out_busy); end
    step(1'b1, 16'hC000);
    n_vec++;
    if (out_update !== 1'b0) begin n_err++; $display("FAIL basic_update_early: got %b expected 0", out_update); end
    step(1'b0, 16'h0000);
    n_vec++;
    if (out_frequency !== 14'd440) begin n_err++; $display("FAIL basic_freq: got %0d expected 440", out_frequency); end
    n_vec++;
    if (out_amplitude !== 8'h80) begin n_err++; $display("FAIL basic_amp: got %h expected 80", out_amplitude); end
    n_vec++;
    if (out_update !== 1'b1) begin n_err++; $display("FAIL basic_update: got %b expected 1", out_update); end
    n_vec++;
    if (out_busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_low: got %b expected 0", out_busy); end
    n_vec++;
    if (out_clamped !== 1'b0) begin n_err++; $display("FAIL basic_clamped: got %b expected 0", out_clamped); end
    step(1'b0, 16'h0000);
    n_vec++;
    if (out_update !== 1'b0) begin n_err++; $display("FAIL basic_update_pulse: got %b expected 0", out_update); end
  endtask

  task automatic test_clamp;
    step(1'b1, 16'h7FFF);
    step(1'b1, 16'hC000);
    step(1'b0, 16'h0000);
    n_vec++;
    if (out_frequency !== 14'd12000) begin n_err++; $display("FAIL clamp_freq: got %0d expected 12000", out_frequency); end
    n_vec++;
    if (out_clamped !== 1'b1) begin n_err++; $display("FAIL clamp_flag: got %b expected 1", out_clamped); end
    n_vec++;
    if (out_amplitude !== 8'h80) begin n_err++; $display("FAIL clamp_amp_kept: got %h expected 80", out_amplitude); end
    step(1'b0, 16'h0000);
  endtask

  task automatic test_commit_idle;
    step(1'b1, 16'hC000);
    n_vec++;
    if (out_frameError !== 1'b0) begin n_err++; $display("FAIL idle_err_early: got %b expected 0", out_frameError); end
    step(1'b0, 16'h0000);
    n_vec++;
    if (out_frameError !== 1'b1) begin n_err++; $display("FAIL idle_err: got %b expected 1", out_frameError); end
    n_vec++;
    if (out_update !== 1'b0) begin n_err++; $display("FAIL idle_no_update: got %b expected 0", out_update); end
    n_vec++;
    if (out_frequency !== 14'd12000) begin n_err++; $display("FAIL idle_freq: got %0d expected 12000", out_frequency); end
    step(1'b0, 16'h0000);
    n_vec++;
    if (out_frameError !== 1'b0) begin n_err++; $display("FAIL idle_err_pulse: got %b expected 0", out_frameError); end
  endtask

  task automatic test_timeout;
    int err_at = -1;
    int err_cnt = 0;
    step(1'b1, 16'h43E8);
    for (int i = 1; i <= TB_TIMEOUT + 4; i++) begin
      step(1'b0, 16'h0000);
      if (out_frameError === 1'b1) begin
        err_cnt++;
        if (err_at < 0) err_at = i;
      end
    end
    // Entry into COLLECT is one cycle after the word; TB_TIMEOUT cycles later the error fires.
    n_vec++;
    if (err_at !== TB_TIMEOUT + 1) begin n_err++; $display("FAIL timeout_cycle: got %0d expected %0d", err_at, TB_TIMEOUT + 1); end
    n_vec++;
    if (err_cnt !== 1) begin n_err++; $display("FAIL timeout_pulses: got %0d expected 1", err_cnt); end
    n_vec++;
    if (out_busy !== 1'b0) begin n_err++; $display("FAIL timeout_busy: got %b expected 0", out_busy); end
    step(1'b1, 16'hC000);
    step(1'b0, 16'h0000);
    n_vec++;
    if (out_frameError !== 1'b1) begin n_err++; $display("FAIL timeout_commit_err: got %b expected 1", out_frameError); end
    n_vec++;
    if (out_frequency !== 14'd12000) begin n_err++; $display("FAIL timeout_freq: got %0d expected 12000", out_frequency); end
    step(1'b0, 16'h0000);
  endtask

  task automatic test_commit_on_timeout;
    int err_cnt = 0;
    step(1'b1, 16'h41F4);
    step(1'b1, 16'h42BC);
    // The FREQ 700 word restarts the timer one cycle from now; COMMIT lands in the register on its last cycle.
    for (int i = 0; i < TB_TIMEOUT - 1; i++) begin
      step(1'b0, 16'h0000);
      if (out_frameError === 1'b1) err_cnt++;
    end
    step(1'b1, 16'hC000);
    if (out_frameError === 1'b1) err_cnt++;
    step(1'b0, 16'h0000);
    n_vec++;
    if (out_update !== 1'b1) begin n_err++; $display("FAIL edge_update: got %b expected 1", out_update); end
    n_vec++;
    if (out_frequency !== 14'd700) begin n_err++; $display("FAIL edge_freq: got %0d expected 700", out_frequency); end
    if (out_frameError === 1'b1) err_cnt++;
    step(1'b0, 16'h0000);
    if (out_frameError === 1'b1) err_cnt++;
    n_vec++;
    if (err_cnt !== 0) begin n_err++; $display("FAIL edge_no_error: got %0d pulses expected 0", err_cnt); end
    n_vec++;
    if (out_amplitude !== 8'h80) begin n_err++; $display("FAIL edge_amp: got %h expected 80", out_amplitude); end
  endtask

  task automatic test_async_reset;
    step(1'b1, 16'h8055);
    step(1'b0, 16'h0000);
    n_vec++;
    if (out_busy !== 1'b1) begin n_err++; $display("FAIL areset_busy_before: got %b expected 1", out_busy); end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({out_frequency, out_amplitude, out_update, out_frameError, out_clamped, out_busy} !== 26'd0) begin
      n_err++;
      $display("FAIL areset_outputs: got %h expected 0",
               {out_frequency, out_amplitude, out_update, out_frameError, out_clamped, out_busy});
    end
    @(negedge CLK_50Mhz);
    reset_n = 1'b1;
    @(negedge CLK_50Mhz);
    step(1'b1, 16'hC000);
    step(1'b0, 16'h0000);
    n_vec++;
    if (out_frameError !== 1'b1) begin n_err++; $display("FAIL areset_commit_err: got %b expected 1", out_frameError); end
    n_vec++;
    if (out_update !== 1'b0 || out_amplitude !== 8'h00) begin
      n_err++;
      $display("FAIL areset_commit_nochange: got update=%b amp=%h expected update=0 amp=00", out_update, out_amplitude);
    end
    step(1'b0, 16'h0000);
  endtask

  task automatic test_back_to_back;
    step(1'b1, 16'h4064);
    step(1'b1, 16'hBF33);
    step(1'b1, 16'hC000);
    step(1'b0, 16'h0000);
    n_vec++;
    if (out_frequency !== 14'd100) begin n_err++; $display("FAIL b2b_freq: got %0d expected 100", out_frequency); end
    n_vec++;
    if (out_amplitude !== 8'h33) begin n_err++; $display("FAIL b2b_amp: got %h expected 33", out_amplitude); end
    n_vec++;
    if (out_update !== 1'b1 || out_clamped !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_flags: got update=%b clamped=%b expected update=1 clamped=0", out_update, out_clamped);
    end
    step(1'b0, 16'h0000);
  endtask

  initial begin
    @(negedge CLK_50Mhz);
    test_reset();
    test_basic_commit();
    test_clamp();
    test_commit_idle();
    test_timeout();
    test_commit_on_timeout();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
